// File: rtl/pd_debug_ram_dp_param.sv
// pd_debug_ram_dp_param: parametrised true-dual-port debug RAM with two Avalon-MM slave ports on one clock.
// The optional clear sequencer is built only when PD_DEBUGRAM_CLEAR_EN is defined.
module pd_debug_ram_dp_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  freeze,
  input  logic                  clear_req,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic                  a_chipselect,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_W/8-1:0]   a_byteenable,
  input  logic [DATA_W-1:0]     a_writedata,
  output logic [DATA_W-1:0]     a_readdata,
  output logic                  a_readdatavalid,
  output logic                  a_waitrequest,
  input  logic [ADDR_W-1:0]     b_address,
  input  logic                  b_chipselect,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_W/8-1:0]   b_byteenable,
  input  logic [DATA_W-1:0]     b_writedata,
  output logic [DATA_W-1:0]     b_readdata,
  output logic                  b_readdatavalid,
  output logic                  b_waitrequest,
  output logic                  collision,
  output logic                  clear_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_d,
    input logic [DATA_W-1:0] new_d,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_d[i*8 +: 8];
      else       res[i*8 +: 8] = old_d[i*8 +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              a_acc_s;
  logic              b_acc_s;
  logic              a_we_s;
  logic              b_we_s;
  logic              same_we_s;
  logic              collision_r;
  logic [1:0]        rd_req_s;
  logic [DATA_W-1:0] rd_word_s [2];
  logic [1:0]        rd_vld_r;
  logic [DATA_W-1:0] rd_data_r [2];

  assign a_acc_s   = a_chipselect & ~busy_s;
  assign b_acc_s   = b_chipselect & ~busy_s;
  assign a_we_s    = a_acc_s & a_write & ~freeze;
  assign b_we_s    = b_acc_s & b_write & ~freeze;
  assign same_we_s = a_we_s & b_we_s & (a_address == b_address);

  assign rd_req_s     = {b_acc_s & b_read, a_acc_s & a_read};
  assign rd_word_s[0] = mem_r[a_address];
  assign rd_word_s[1] = mem_r[b_address];

`ifdef PD_DEBUGRAM_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  clr_state_e        state_r;
  clr_state_e        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;

  // Clear sequencer state and address counter; reset restarts the clear at word 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: one zero word per cycle, leave CLEAR after the last address.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        cnt_s = cnt_r + 1'b1;
        if (&cnt_r) state_s = ST_READY;
        else        state_s = ST_CLEAR;
      end
      ST_READY: begin
        cnt_s = '0;
        if (clear_req) state_s = ST_CLEAR;
        else           state_s = ST_READY;
      end
      default: begin
        state_s = ST_CLEAR;
        cnt_s   = '0;
      end
    endcase
  end

  assign busy_s     = (state_r == ST_CLEAR);
  assign clr_we_s   = busy_s;
  assign clr_addr_s = cnt_r;
`else
  logic unused_clear_req_s;
  assign unused_clear_req_s = clear_req;
  assign busy_s     = 1'b0;
  assign clr_we_s   = 1'b0;
  assign clr_addr_s = '0;
`endif

  // RAM array: clear writes win; on a same-address collision A's lanes overlay B's.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= '0;
    end else begin
      if (a_we_s) begin
        mem_r[a_address] <= be_merge(
          same_we_s ? be_merge(mem_r[a_address], b_writedata, b_byteenable) : mem_r[a_address],
          a_writedata, a_byteenable);
      end
      if (b_we_s && !same_we_s) begin
        mem_r[b_address] <= be_merge(mem_r[b_address], b_writedata, b_byteenable);
      end
    end
  end

  // Collision flag: both ports wrote one address, flagged even when freeze drops the data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision_r <= 1'b0;
    end else begin
      collision_r <= a_acc_s & a_write & b_acc_s & b_write & (a_address == b_address);
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0]        p1_vld_r;
      logic [DATA_W-1:0] p1_data_r [2];

      // Two-stage read pipeline; readdata holds its last value between reads.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p1_vld_r <= 2'b00;
          rd_vld_r <= 2'b00;
          for (int p = 0; p < 2; p++) begin
            p1_data_r[p] <= '0;
            rd_data_r[p] <= '0;
          end
        end else begin
          p1_vld_r <= rd_req_s;
          rd_vld_r <= p1_vld_r;
          for (int p = 0; p < 2; p++) begin
            if (rd_req_s[p]) p1_data_r[p] <= rd_word_s[p];
            if (p1_vld_r[p]) rd_data_r[p] <= p1_data_r[p];
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read pipeline; the array is sampled before this edge's write lands.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_vld_r <= 2'b00;
          for (int p = 0; p < 2; p++) begin
            rd_data_r[p] <= '0;
          end
        end else begin
          rd_vld_r <= rd_req_s;
          for (int p = 0; p < 2; p++) begin
            if (rd_req_s[p]) rd_data_r[p] <= rd_word_s[p];
          end
        end
      end
    end
  endgenerate

  assign a_readdata      = rd_data_r[0];
  assign a_readdatavalid = rd_vld_r[0];
  assign b_readdata      = rd_data_r[1];
  assign b_readdatavalid = rd_vld_r[1];
  assign a_waitrequest   = busy_s;
  assign b_waitrequest   = busy_s;
  assign clear_busy      = busy_s;
  assign collision       = collision_r;

endmodule

// File: tb/tb_pd_debug_ram_dp_param.sv
// Bench for pd_debug_ram_dp_param: latency-1 and latency-2 instances driven identically and checked against
// a word-array reference model; clear-sequencer checks are built when PD_DEBUGRAM_CLEAR_EN is defined.
module tb_pd_debug_ram_dp_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int OBW   = 140;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, freeze, clear_req;
  logic [AW-1:0] a_address, b_address;
  logic          a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
  logic [BW-1:0] a_byteenable, b_byteenable;
  logic [DW-1:0] a_writedata, b_writedata;

  logic [DW-1:0] a_rd_l1, b_rd_l1, a_rd_l2, b_rd_l2;
  logic          a_rdv_l1, b_rdv_l1, a_rdv_l2, b_rdv_l2;
  logic          a_wait_l1, b_wait_l1, a_wait_l2, b_wait_l2;
  logic          coll_l1, coll_l2, busy_l1, busy_l2;

  int errors = 0;
  int checks = 0;

  pd_debug_ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .clear_req(clear_req),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_rd_l1),
    .a_readdatavalid(a_rdv_l1), .a_waitrequest(a_wait_l1),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b_rd_l1),
    .b_readdatavalid(b_rdv_l1), .b_waitrequest(b_wait_l1),
    .collision(coll_l1), .clear_busy(busy_l1)
  );

  pd_debug_ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .clear_req(clear_req),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_rd_l2),
    .a_readdatavalid(a_rdv_l2), .a_waitrequest(a_wait_l2),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b_rd_l2),
    .b_readdatavalid(b_rdv_l2), .b_waitrequest(b_wait_l2),
    .collision(coll_l2), .clear_busy(busy_l2)
  );

  // Reference model: word array, latest read result, the one before it, last-returned data per latency.
  logic [DW-1:0] mem_m [DEPTH];
  logic          a_cur_v, b_cur_v, a_prev_v, b_prev_v, coll_e;
  logic [DW-1:0] a_cur_d, b_cur_d, a_prev_d, b_prev_d;
  logic [DW-1:0] a_hold1, b_hold1, a_hold2, b_hold2;
  int            clear_left;

  function automatic void model_reset();
    a_cur_v = 1'b0; b_cur_v = 1'b0; a_prev_v = 1'b0; b_prev_v = 1'b0; coll_e = 1'b0;
    a_cur_d = '0; b_cur_d = '0; a_prev_d = '0; b_prev_d = '0;
    a_hold1 = '0; b_hold1 = '0; a_hold2 = '0; b_hold2 = '0;
`ifdef PD_DEBUGRAM_CLEAR_EN
    clear_left = DEPTH;
`else
    clear_left = 0;
`endif
  endfunction

  function automatic void model_edge();
    bit busy  = (clear_left > 0);
    bit a_acc = a_chipselect && !busy;
    bit b_acc = b_chipselect && !busy;
    a_prev_v = a_cur_v; a_prev_d = a_cur_d;
    b_prev_v = b_cur_v; b_prev_d = b_cur_d;
    a_cur_v = a_acc && a_read;
    b_cur_v = b_acc && b_read;
    if (a_cur_v) a_cur_d = mem_m[a_address];
    if (b_cur_v) b_cur_d = mem_m[b_address];
    if (a_cur_v) a_hold1 = a_cur_d;
    if (b_cur_v) b_hold1 = b_cur_d;
    if (a_prev_v) a_hold2 = a_prev_d;
    if (b_prev_v) b_hold2 = b_prev_d;
    coll_e = a_acc && a_write && b_acc && b_write && (a_address == b_address);
    if (busy) begin
      mem_m[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (!freeze) begin
        for (int i = 0; i < BW; i++)
          if (b_acc && b_write && b_byteenable[i]) mem_m[b_address][i*8 +: 8] = b_writedata[i*8 +: 8];
        for (int i = 0; i < BW; i++)
          if (a_acc && a_write && a_byteenable[i]) mem_m[a_address][i*8 +: 8] = a_writedata[i*8 +: 8];
      end
`ifdef PD_DEBUGRAM_CLEAR_EN
      if (clear_req) clear_left = DEPTH;
`endif
    end
  endfunction

  function automatic logic [OBW-1:0] obs_bundle();
    return {a_rdv_l1, a_rd_l1, b_rdv_l1, b_rd_l1, a_rdv_l2, a_rd_l2, b_rdv_l2, b_rd_l2,
            coll_l1, coll_l2, busy_l1, busy_l2, a_wait_l1, b_wait_l1, a_wait_l2, b_wait_l2};
  endfunction

  function automatic logic [OBW-1:0] exp_bundle();
    logic bz = (clear_left > 0);
    return {a_cur_v, a_hold1, b_cur_v, b_hold1, a_prev_v, a_hold2, b_prev_v, b_hold2,
            coll_e, coll_e, bz, bz, bz, bz, bz, bz};
  endfunction

  task automatic idle();
    a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0; a_address = 4'd0;
    a_byteenable = 4'h0; a_writedata = 32'h0;
    b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0; b_address = 4'd0;
    b_byteenable = 4'h0; b_writedata = 32'h0;
    freeze = 1'b0; clear_req = 1'b0;
  endtask

  task automatic set_a(input logic rd, input logic wr, input logic [AW-1:0] ad,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    a_chipselect = 1'b1; a_read = rd; a_write = wr; a_address = ad; a_byteenable = be; a_writedata = wd;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [AW-1:0] ad,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    b_chipselect = 1'b1; b_read = rd; b_write = wr; b_address = ad; b_byteenable = be; b_writedata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle();
    idle();
    while (clear_left > 0) step();
    step();
    step();
  endtask

  task automatic test_reset();
    logic [OBW-1:0] o, e;
    idle();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    o = obs_bundle(); e = exp_bundle();
    checks++;
    if (o !== e) begin $display("FAIL reset_state got %h want %h", o, e); errors++; end
    reset_n = 1'b1;
`ifdef PD_DEBUGRAM_CLEAR_EN
    begin
      int n;
      n = (busy_l1 && busy_l2 && a_wait_l1 && b_wait_l1 && a_wait_l2 && b_wait_l2) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (busy_l1 && busy_l2 && a_wait_l1 && b_wait_l1 && a_wait_l2 && b_wait_l2) n++;
        o = obs_bundle(); e = exp_bundle();
        checks++;
        if (o !== e) begin $display("FAIL reset_clear cyc %0d got %h want %h", i, o, e); errors++; end
      end
      checks++;
      if (n !== 16) begin $display("FAIL reset_clear_len got %0d want 16", n); errors++; end
      for (int i = 0; i < DEPTH; i++) begin
        idle(); set_a(1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
        step();
        checks++;
        if (a_rdv_l1 !== 1'b1 || a_rd_l1 !== 32'h0) begin
          $display("FAIL reset_clear_zero addr %0d got %b/%h want 1/0", i, a_rdv_l1, a_rd_l1); errors++;
        end
      end
      settle();
    end
`else
    step();
    o = obs_bundle(); e = exp_bundle();
    checks++;
    if (o !== e) begin $display("FAIL reset_release got %h want %h", o, e); errors++; end
`endif
  endtask

  task automatic test_fill();
    logic [OBW-1:0] o, e;
    settle();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_a(1'b0, 1'b1, 4'(i), 4'hF, $urandom);
      step();
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle();
      if (i < DEPTH) begin
        set_b(1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
        set_a(1'b1, 1'b0, 4'(DEPTH - 1 - i), 4'h0, 32'h0);
      end
      step();
      o = obs_bundle(); e = exp_bundle();
      checks++;
      if (o !== e) begin $display("FAIL fill_readback cyc %0d got %h want %h", i, o, e); errors++; end
    end
  endtask

  task automatic test_roundtrip();
    settle();
    set_a(1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF); step();
    idle(); set_a(1'b1, 1'b0, 4'd3, 4'h0, 32'h0); step();
    checks++;
    if (a_rdv_l1 !== 1'b1 || a_rd_l1 !== 32'hDEADBEEF) begin
      $display("FAIL roundtrip_l1 got %b/%h want 1/deadbeef", a_rdv_l1, a_rd_l1); errors++;
    end
    idle(); step();
    checks++;
    if (a_rdv_l1 !== 1'b0 || a_rdv_l2 !== 1'b1 || a_rd_l2 !== 32'hDEADBEEF || a_rd_l1 !== 32'hDEADBEEF) begin
      $display("FAIL roundtrip_l2 got %b/%b/%h want 0/1/deadbeef", a_rdv_l1, a_rdv_l2, a_rd_l2); errors++;
    end
  endtask

  task automatic test_partial_be();
    settle();
    set_a(1'b0, 1'b1, 4'd5, 4'hF, 32'h11223344); step();
    idle(); set_b(1'b0, 1'b1, 4'd5, 4'b0101, 32'hAABBCCDD); step();
    idle(); set_a(1'b1, 1'b0, 4'd5, 4'h0, 32'h0); step();
    checks++;
    if (a_rdv_l1 !== 1'b1 || a_rd_l1 !== 32'h11BB33DD) begin
      $display("FAIL partial_be got %b/%h want 1/11bb33dd", a_rdv_l1, a_rd_l1); errors++;
    end
    idle(); step();
  endtask

  task automatic test_collision();
    settle();
    set_a(1'b0, 1'b1, 4'd7, 4'b0001, 32'h000000FF);
    set_b(1'b0, 1'b1, 4'd7, 4'hF, 32'hFFFFFF00);
    step();
    checks++;
    if (coll_l1 !== 1'b1 || coll_l2 !== 1'b1) begin
      $display("FAIL collision_pulse got %b%b want 11", coll_l1, coll_l2); errors++;
    end
    idle(); step();
    checks++;
    if (coll_l1 !== 1'b0 || coll_l2 !== 1'b0) begin
      $display("FAIL collision_width got %b%b want 00", coll_l1, coll_l2); errors++;
    end
    freeze = 1'b1;
    set_a(1'b0, 1'b1, 4'd7, 4'hF, 32'h01010101);
    set_b(1'b0, 1'b1, 4'd7, 4'hF, 32'h02020202);
    step();
    checks++;
    if (coll_l1 !== 1'b1) begin $display("FAIL collision_frozen got %b want 1", coll_l1); errors++; end
    idle(); set_a(1'b1, 1'b0, 4'd7, 4'h0, 32'h0); step();
    checks++;
    if (a_rd_l1 !== 32'hFFFFFFFF || coll_l1 !== 1'b0) begin
      $display("FAIL collision_data got %h/%b want ffffffff/0", a_rd_l1, coll_l1); errors++;
    end
    idle(); step();
  endtask

  task automatic test_freeze_rdw();
    settle();
    set_a(1'b0, 1'b1, 4'd2, 4'hF, 32'h0); step();
    freeze = 1'b1; set_a(1'b0, 1'b1, 4'd2, 4'hF, 32'h12345678); step();
    idle(); set_a(1'b1, 1'b0, 4'd2, 4'h0, 32'h0); step();
    checks++;
    if (a_rd_l1 !== 32'h0) begin $display("FAIL freeze_write got %h want 0", a_rd_l1); errors++; end
    idle(); set_a(1'b0, 1'b1, 4'd2, 4'hF, 32'h5); set_b(1'b1, 1'b0, 4'd2, 4'h0, 32'h0); step();
    checks++;
    if (b_rdv_l1 !== 1'b1 || b_rd_l1 !== 32'h0) begin
      $display("FAIL mixed_rdw_old got %b/%h want 1/0", b_rdv_l1, b_rd_l1); errors++;
    end
    idle(); set_b(1'b1, 1'b0, 4'd2, 4'h0, 32'h0); step();
    checks++;
    if (b_rd_l1 !== 32'h5 || b_rd_l2 !== 32'h0) begin
      $display("FAIL mixed_rdw_new got %h/%h want 5/0", b_rd_l1, b_rd_l2); errors++;
    end
    idle(); set_a(1'b1, 1'b1, 4'd2, 4'hF, 32'h9); step();
    checks++;
    if (a_rd_l1 !== 32'h5 || b_rd_l2 !== 32'h5) begin
      $display("FAIL same_port_rdw got %h/%h want 5/5", a_rd_l1, b_rd_l2); errors++;
    end
    idle(); step();
  endtask

  task automatic test_back_to_back();
    logic [OBW-1:0] o, e;
    logic ev1, ev2;
    settle();
    for (int s = 0; s < 6; s++) begin
      idle();
      if (s < 4) set_a(1'b1, 1'b0, 4'(s), 4'h0, 32'h0);
      step();
      ev1 = (s < 4);
      ev2 = (s >= 1 && s <= 4);
      checks++;
      if (a_rdv_l1 !== ev1 || a_rdv_l2 !== ev2) begin
        $display("FAIL b2b_valid s %0d got %b%b want %b%b", s, a_rdv_l1, a_rdv_l2, ev1, ev2); errors++;
      end
      if (ev2) begin
        checks++;
        if (a_rd_l2 !== mem_m[s-1]) begin
          $display("FAIL b2b_data s %0d got %h want %h", s, a_rd_l2, mem_m[s-1]); errors++;
        end
      end
      o = obs_bundle(); e = exp_bundle();
      checks++;
      if (o !== e) begin $display("FAIL b2b_bundle s %0d got %h want %h", s, o, e); errors++; end
    end
  endtask

  task automatic test_reset_pending();
    logic [OBW-1:0] o, e;
    settle();
    set_a(1'b1, 1'b0, 4'd1, 4'h0, 32'h0);
    @(posedge clk);
    model_edge();
    #2;
    reset_n = 1'b0;
    model_reset();
    idle();
    #1;
    o = obs_bundle(); e = exp_bundle();
    checks++;
    if (o !== e) begin $display("FAIL reset_mid_read got %h want %h", o, e); errors++; end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_rdv_l1 !== 1'b0 || a_rdv_l2 !== 1'b0) begin
        $display("FAIL reset_flush cyc %0d got %b%b want 00", i, a_rdv_l1, a_rdv_l2); errors++;
      end
    end
    settle();
  endtask

  task automatic test_random();
    logic [OBW-1:0] o, e;
    settle();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_b(1'b0, 1'b1, 4'(i), 4'hF, $urandom); step();
    end
    for (int i = 0; i < 300; i++) begin
      a_chipselect = ($urandom_range(0, 3) != 0);
      a_read = 1'($urandom_range(0, 1)); a_write = 1'($urandom_range(0, 1));
      a_address = 4'($urandom_range(0, 3)); a_byteenable = 4'($urandom_range(0, 15)); a_writedata = $urandom;
      b_chipselect = ($urandom_range(0, 3) != 0);
      b_read = 1'($urandom_range(0, 1)); b_write = 1'($urandom_range(0, 1));
      b_address = 4'($urandom_range(0, 3)); b_byteenable = 4'($urandom_range(0, 15)); b_writedata = $urandom;
      freeze = ($urandom_range(0, 7) == 0);
      clear_req = ($urandom_range(0, 63) == 0);
      step();
      o = obs_bundle(); e = exp_bundle();
      checks++;
      if (o !== e) begin $display("FAIL random cyc %0d got %h want %h", i, o, e); errors++; end
    end
    idle(); step(); step();
  endtask

`ifdef PD_DEBUGRAM_CLEAR_EN
  task automatic test_clear_req();
    int n;
    settle();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_a(1'b0, 1'b1, 4'(i), 4'hF, 32'hA5A50000 | 32'(i + 1)); step();
    end
    idle(); clear_req = 1'b1; step();
    clear_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_l1 && busy_l2 && a_wait_l1 && b_wait_l1) n++;
      step();
    end
    checks++;
    if (n !== 16) begin $display("FAIL clear_req_len got %0d want 16", n); errors++; end
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_b(1'b1, 1'b0, 4'(i), 4'h0, 32'h0); step();
      checks++;
      if (b_rdv_l1 !== 1'b1 || b_rd_l1 !== 32'h0) begin
        $display("FAIL clear_req_zero addr %0d got %b/%h want 1/0", i, b_rdv_l1, b_rd_l1); errors++;
      end
    end
  endtask
`endif

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_roundtrip();
    test_partial_be();
    test_collision();
    test_freeze_rdw();
    test_back_to_back();
    test_reset_pending();
    test_random();
`ifdef PD_DEBUGRAM_CLEAR_EN
    test_clear_req();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
